// File: rtl/ahb_noc_pkg.sv
// Shared definitions for the AHB-Lite NoC transmit/receive interfaces:
// register map, header layout and transmit state encoding.
package ahb_noc_pkg;

  localparam logic [1:0] No_Transfer = 2'b00;

  localparam logic [4:0] DATA0   = 5'd0;
  localparam logic [4:0] MSG_LEN = 5'd8;
  localparam logic [4:0] ADDR    = 5'd9;
  localparam logic [4:0] STATUS  = 5'd16;
  localparam logic [4:0] CONTROL = 5'd17;

  localparam int unsigned HDR_DEST_LSB = 24;
  localparam int unsigned HDR_SRC_LSB  = 16;
  localparam int unsigned HDR_LEN_LSB  = 8;

  localparam int unsigned MAX_FLITS = 8;

  typedef enum logic [1:0] {IDLE, READY, HEADER, SEND} tx_state_t;

  function automatic logic [31:0] make_header(input logic [3:0] dest,
                                              input logic [3:0] src,
                                              input logic [5:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_DEST_LSB +: 4] = dest;
    h[HDR_SRC_LSB  +: 4] = src;
    h[HDR_LEN_LSB  +: 6] = len;
    return h;
  endfunction

  // Byte length must be a whole number of words, 1..MAX_FLITS words.
  function automatic logic len_legal(input logic [5:0] len);
    return (len != 6'd0) && (len <= 6'd32) && (len[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ahb_tx.sv
// AHB-Lite slave that builds one NoC packet (header + up to eight data
// flits) from software-written registers and streams it on M_Req/M_Data.
module ahb_tx
  import ahb_noc_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic [3:0]  Node_Addr,
  output logic        M_Req,
  output logic [31:0] M_Data,
  input  logic        M_Ack
);

  logic        write_en;
  logic        read_en;
  logic [4:0]  word_addr;
  logic [31:0] tx_data [MAX_FLITS];
  logic [5:0]  msg_len;
  logic [3:0]  dest_addr;
  logic        error;
  logic [2:0]  ptr;
  tx_state_t   state;

  logic        busy;
  logic        start_req;
  logic        last_flit;
  logic        unused_bits;

  assign HREADYOUT   = 1'b1;
  assign busy        = (state == HEADER) || (state == SEND);
  assign start_req   = write_en && (word_addr == CONTROL) && HWDATA[0] && !busy;
  assign last_flit   = ({1'b0, ptr} == (msg_len[5:2] - 4'd1));
  assign unused_bits = ^{HSIZE, HADDR[31:7], HADDR[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      word_addr <= '0;
    end else if (HREADY && HSEL && (HTRANS != No_Transfer)) begin
      write_en  <= HWRITE;
      read_en   <= !HWRITE;
      word_addr <= HADDR[6:2];
    end else begin
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      word_addr <= '0;
    end
  end

  // Packet registers are frozen while a packet is in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < MAX_FLITS; i++) tx_data[i] <= '0;
      msg_len   <= '0;
      dest_addr <= '0;
    end else if (write_en && !busy) begin
      if (word_addr[4:3] == 2'b00)
        tx_data[word_addr[2:0]] <= HWDATA;
      else if (word_addr == MSG_LEN)
        msg_len <= HWDATA[5:0];
      else if (word_addr == ADDR)
        dest_addr <= HWDATA[3:0];
    end
  end

  always_comb begin
    HRDATA = '0;
    if (read_en) begin
      if (word_addr[4:3] == 2'b00)
        HRDATA = tx_data[word_addr[2:0]];
      else if (word_addr == MSG_LEN)
        HRDATA[5:0] = msg_len;
      else if (word_addr == ADDR)
        HRDATA[3:0] = dest_addr;
      else if (word_addr == STATUS)
        HRDATA[1:0] = {error, busy};
    end
  end

  // M_Data is preloaded one edge ahead, so ptr always names the word on the wire.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      M_Req  <= 1'b0;
      M_Data <= '0;
      ptr    <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= READY;
          M_Req  <= 1'b0;
          M_Data <= '0;
        end
        READY: begin
          if (start_req) begin
            if (len_legal(msg_len)) begin
              error  <= 1'b0;
              state  <= HEADER;
              M_Req  <= 1'b1;
              M_Data <= make_header(dest_addr, Node_Addr, msg_len);
            end else begin
              error  <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (M_Ack) begin
            state  <= SEND;
            ptr    <= '0;
            M_Data <= tx_data[0];
          end
        end
        SEND: begin
          if (last_flit) begin
            state  <= READY;
            M_Req  <= 1'b0;
            M_Data <= '0;
            ptr    <= '0;
          end else begin
            ptr    <= ptr + 3'd1;
            M_Data <= tx_data[ptr + 3'd1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_tx.sv
// Directed bench for ahb_tx: register map vectors plus packet sequences.
module tb_ahb_tx;
  import ahb_noc_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [3:0]  Node_Addr;
  logic        M_Req;
  logic [31:0] M_Data;
  logic        M_Ack;

  int checks;
  int failures;

  ahb_tx dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSEL      (HSEL),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .Node_Addr (Node_Addr),
    .M_Req     (M_Req),
    .M_Data    (M_Data),
    .M_Ack     (M_Ack)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HADDR  = addr;
    HWRITE = 1'b1;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HADDR  = addr;
    HWRITE = 1'b0;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic read_chk(input string name, input logic [4:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read({25'd0, idx, 2'b00}, d);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] words [8];
    checks    = 0;
    failures  = 0;
    HRESETn   = 1'b0;
    HADDR     = '0;
    HWDATA    = '0;
    HSIZE     = 3'b010;
    HTRANS    = 2'b00;
    HWRITE    = 1'b0;
    HREADY    = 1'b1;
    HSEL      = 1'b0;
    Node_Addr = 4'b1001;
    M_Ack     = 1'b1;

    vecs[0]  = '{32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
    vecs[1]  = '{32'h0000_0014, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2]  = '{32'h0000_001C, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{32'h0000_0404, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4]  = '{32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_003F};
    vecs[5]  = '{32'h0000_0020, 32'h0000_0010, 32'h0000_0010};
    vecs[6]  = '{32'h0000_0024, 32'hFFFF_FFF5, 32'h0000_0005};
    vecs[7]  = '{32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{32'h0000_0044, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0050, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{32'h0000_007C, 32'hCAFE_BABE, 32'h0000_0000};

    #12;
    chk("rst_mreq", {31'd0, M_Req}, 32'd0);
    chk("rst_mdata", M_Data, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;

    for (int unsigned i = 0; i < 18; i++)
      read_chk($sformatf("rst_reg%0d", i), 5'(i), 32'd0);
    chk("rst_mreq_idle", {31'd0, M_Req}, 32'd0);

    for (int unsigned i = 0; i < 11; i++) begin
      ahb_write(vecs[i].addr, vecs[i].wdata);
      ahb_read(vecs[i].addr, d);
      chk($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Basic 3-word packet with M_Ack held high.
    ahb_write({25'd0, 5'd0, 2'b00}, 32'hA0);
    ahb_write({25'd0, 5'd1, 2'b00}, 32'hA1);
    ahb_write({25'd0, 5'd2, 2'b00}, 32'hA2);
    ahb_write({25'd0, MSG_LEN, 2'b00}, 32'd12);
    ahb_write({25'd0, ADDR, 2'b00}, 32'h6);
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    @(negedge HCLK);
    chk("p1_hdr_req", {31'd0, M_Req}, 32'd1);
    chk("p1_hdr", M_Data, 32'h0609_0C00);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk($sformatf("p1_req%0d", i), {31'd0, M_Req}, 32'd1);
      chk($sformatf("p1_data%0d", i), M_Data, 32'hA0 + i);
    end
    @(negedge HCLK);
    chk("p1_end_req", {31'd0, M_Req}, 32'd0);
    chk("p1_end_data", M_Data, 32'd0);
    @(posedge HCLK); #1;

    // Header held while M_Ack is low.
    M_Ack = 1'b0;
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge HCLK);
      chk($sformatf("hold_req%0d", i), {31'd0, M_Req}, 32'd1);
      chk($sformatf("hold_hdr%0d", i), M_Data, 32'h0609_0C00);
    end
    @(posedge HCLK); #1;
    read_chk("hold_status_a", STATUS, 32'h1);
    read_chk("hold_status_b", STATUS, 32'h1);
    M_Ack = 1'b1;
    @(negedge HCLK);
    chk("hold_last_hdr", M_Data, 32'h0609_0C00);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk($sformatf("hold_data%0d", i), M_Data, 32'hA0 + i);
    end
    @(negedge HCLK);
    chk("hold_end_req", {31'd0, M_Req}, 32'd0);
    @(posedge HCLK); #1;
    read_chk("hold_status_done", STATUS, 32'h0);

    // Full 8-word packet.
    for (int unsigned i = 0; i < 8; i++) begin
      words[i] = 32'hB0 + i;
      ahb_write({25'd0, 5'(i), 2'b00}, words[i]);
    end
    ahb_write({25'd0, MSG_LEN, 2'b00}, 32'd32);
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    @(negedge HCLK);
    chk("p8_hdr", M_Data, 32'h0609_2000);
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge HCLK);
      chk($sformatf("p8_req%0d", i), {31'd0, M_Req}, 32'd1);
      chk($sformatf("p8_data%0d", i), M_Data, words[i]);
    end
    @(negedge HCLK);
    chk("p8_end_req", {31'd0, M_Req}, 32'd0);
    @(posedge HCLK); #1;

    // Illegal lengths set Error and send nothing.
    ahb_write({25'd0, MSG_LEN, 2'b00}, 32'd0);
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    @(negedge HCLK);
    chk("len0_req", {31'd0, M_Req}, 32'd0);
    @(posedge HCLK); #1;
    read_chk("len0_status", STATUS, 32'h2);
    ahb_write({25'd0, MSG_LEN, 2'b00}, 32'd36);
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    @(negedge HCLK);
    chk("len36_req", {31'd0, M_Req}, 32'd0);
    @(posedge HCLK); #1;
    read_chk("len36_status", STATUS, 32'h2);
    ahb_write({25'd0, MSG_LEN, 2'b00}, 32'd6);
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    @(negedge HCLK);
    chk("len6_req", {31'd0, M_Req}, 32'd0);
    @(posedge HCLK); #1;
    read_chk("len6_status", STATUS, 32'h2);
    ahb_write({25'd0, MSG_LEN, 2'b00}, 32'd4);
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    @(negedge HCLK);
    chk("len4_hdr", M_Data, 32'h0609_0400);
    @(negedge HCLK);
    chk("len4_data", M_Data, 32'hB0);
    @(negedge HCLK);
    chk("len4_end_req", {31'd0, M_Req}, 32'd0);
    @(posedge HCLK); #1;
    read_chk("len4_status", STATUS, 32'h0);

    // Writes and Start during SEND are ignored.
    ahb_write({25'd0, MSG_LEN, 2'b00}, 32'd32);
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    fork
      begin
        ahb_write({25'd0, 5'd1, 2'b00}, 32'hDEAD_0001);
        ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
      end
      begin
        @(negedge HCLK);
        chk("busy_hdr", M_Data, 32'h0609_2000);
        for (int unsigned i = 0; i < 8; i++) begin
          @(negedge HCLK);
          chk($sformatf("busy_data%0d", i), M_Data, words[i]);
        end
        @(negedge HCLK);
        chk("busy_end_req", {31'd0, M_Req}, 32'd0);
      end
    join
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk($sformatf("busy_no_resend%0d", i), {31'd0, M_Req}, 32'd0);
    end
    @(posedge HCLK); #1;
    read_chk("busy_data1_kept", 5'd1, 32'hB1);
    read_chk("busy_status", STATUS, 32'h0);

    // Reset in the middle of SEND.
    ahb_write({25'd0, CONTROL, 2'b00}, 32'h1);
    @(negedge HCLK);
    @(negedge HCLK);
    @(negedge HCLK);
    chk("mid_pre_data", M_Data, 32'hB1);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, M_Req}, 32'd0);
    chk("mid_rst_data", M_Data, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("mid_after_req", {31'd0, M_Req}, 32'd0);
    read_chk("mid_reg0", 5'd0, 32'd0);
    read_chk("mid_reg7", 5'd7, 32'd0);
    read_chk("mid_len", MSG_LEN, 32'd0);
    read_chk("mid_addr", ADDR, 32'd0);
    read_chk("mid_status", STATUS, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
